opb_register_bank_simulink2ppc: RTL and testbench
=================================================

Name: opb_register_bank_simulink2ppc

Overview:
Parametrised successor to the single-word simulink2ppc software register. It exposes C_NUM_REGS fabric-to-PPC status words on one OPB slave window, each configurable as live, snapshot or sticky (clear-on-read), plus one control/status word. User logic runs on OPB_Clk, so there is no clock-domain crossing. It sits in the XPS base system alongside the other OPB register wrappers.

Parameters:
C_BASEADDR, 32'h01002300, first byte address of the window
C_HIGHADDR, 32'h010023FF, last byte address of the window
C_OPB_AWIDTH, 32, OPB address width
C_OPB_DWIDTH, 32, OPB data width (fixed 32)
C_NUM_REGS, 4, number of user data words (1..16)
C_USER_DWIDTH, 32, bits per user word (1..32), zero-extended into the MSBs on read
C_SNAP_MASK, 16'h0000, bit i=1: register i is snapshot
C_STICKY_MASK, 16'h0000, bit i=1: register i is sticky-OR; snap takes precedence if both are set

Ports:
OPB_Clk  in  1  single clock for OPB and user logic
OPB_Rst  in  1  synchronous reset, active-low (0 = reset)
OPB_ABus  in  32  address
OPB_BE  in  4  byte enables, [3] = least significant byte
OPB_DBus  in  32  write data, bit 0 = MSB
OPB_RNW  in  1  1 = read
OPB_select  in  1  transaction valid
OPB_seqAddr  in  1  ignored
Sl_DBus  out  32  read data, bit 0 = MSB
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_in  in  C_NUM_REGS*C_USER_DWIDTH  word i at [i*W +: W]
user_capture_in  in  1  one-cycle strobe that snapshots all snap registers

Behaviour:
- Reset, sampled while OPB_Rst=0 on a clock edge:
  - All Sl_* outputs are 0.
  - Snapshot and sticky registers are 0; capture counter is 0; FSM is IDLE.
  - Reset mid-transaction returns to IDLE with no ack issued.
- Address decode: hit = OPB_select & C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index = (OPB_ABus - C_BASEADDR) >> 2.
- FSM states IDLE, ACK, HOLD:
  - IDLE: on hit, go to ACK. The read value is registered from the state in that cycle.
  - ACK: Sl_xferAck=1 for exactly one cycle. Sl_DBus = read value if OPB_RNW=1, else 0. Next state is HOLD.
  - HOLD: one dead cycle in which select is ignored, which prevents a double ack. Next state is IDLE.
  - Latency: ack appears 2 cycles after select is first sampled high. Minimum of 3 cycles between acks.
- Sl_DBus is 0 whenever Sl_xferAck=0, as required by the OR-bus.
- Map, by word index:
  - 0..C_NUM_REGS-1: data registers. Writes to them are acked and have no effect.
  - C_NUM_REGS: control/status word.
    - Write, honoured only if OPB_BE[3]=1: bit 31 (LSB) = software capture; bit 30 = clear all sticky registers.
    - Read returns {16'h0, capture_count[15:0]}.
  - Any other index inside the window: ack, read 0, write ignored.
- Addresses outside the window: no response; Sl_xferAck stays 0.
- Register modes:
  - Live: read returns the user_data_in slice from the IDLE->ACK decision cycle.
  - Snapshot:
    - Loads the slice on a capture event: user_capture_in=1 or a software capture write in its ACK cycle.
    - Both in the same cycle count as one event.
    - Each event increments capture_count by 1, wrapping 0xFFFF->0x0000.
  - Sticky:
    - Every cycle, sticky <= sticky | data.
    - A read of that word clears it in the ACK cycle; data bits present in that same cycle are kept (sticky <= data).
    - A clear-all write behaves the same way.
    - The read returns the accumulated value captured at decision time.
- Width: words narrower than 32 are zero-extended, placing the user LSB at Sl_DBus[31].

Test Plan:
1. Hold OPB_Rst=0 for 3 cycles with select and capture asserted -> all Sl_*=0, no ack; after release, control read = 0x00000000.
2. C_NUM_REGS=4, W=16, live. user word2=0xBEEF, read 0x01002308 -> single ack 2 cycles after select, Sl_DBus=0x0000BEEF; Sl_DBus=0 on all other cycles.
3. Snap mask=0x1. word0=0x1234, pulse user_capture_in, then change word0 to 0x5678 -> read word0 returns 0x1234. Control read returns 0x00000001. Capture strobe and software capture in the same cycle -> count 2, not 3.
4. Sticky mask=0x2. Pulse bit0 and then bit4 of word1 on separate cycles -> read returns 0x11; second read returns 0x0. A bit set during the ACK cycle survives into the next read.
5. Read 0x010023F0 (unused index) -> ack with 0. Read 0x01002400 -> no ack for 20 cycles. Write control with BE=4'b1110 -> no capture.
6. Perform 65536 captures -> count wraps to 0x0000. Back-to-back selects -> acks separated by at least 3 cycles, never two consecutive.

Source files
------------

// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave window: C_NUM_REGS fabric status words (live/snapshot/sticky) plus one control/status word.
// Ack two edges after select is sampled, then one dead cycle; bus vector bit 0 here is OPB big-endian bit 31.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR    = 32'h01002300,
    parameter logic [31:0] C_HIGHADDR    = 32'h010023FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 4,
    parameter int          C_USER_DWIDTH = 32,
    parameter logic [15:0] C_SNAP_MASK   = 16'h0000,
    parameter logic [15:0] C_STICKY_MASK = 16'h0000
) (
    input  logic                                  OPB_Clk,
    input  logic                                  OPB_Rst,
    input  logic [C_OPB_AWIDTH-1:0]               OPB_ABus,
    input  logic [C_OPB_DWIDTH/8-1:0]             OPB_BE,
    input  logic [C_OPB_DWIDTH-1:0]               OPB_DBus,
    input  logic                                  OPB_RNW,
    input  logic                                  OPB_select,
    input  logic                                  OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0]               Sl_DBus,
    output logic                                  Sl_xferAck,
    output logic                                  Sl_errAck,
    output logic                                  Sl_retry,
    output logic                                  Sl_toutSup,
    input  logic [C_NUM_REGS*C_USER_DWIDTH-1:0]   user_data_in,
    input  logic                                  user_capture_in
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    localparam int                      L_IW   = C_OPB_AWIDTH - 2;
    localparam logic [C_OPB_AWIDTH-1:0] L_BASE = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] L_HIGH = C_OPB_AWIDTH'(C_HIGHADDR);
    localparam logic [L_IW-1:0]         L_CTRL = L_IW'(C_NUM_REGS);

    state_t                     r_state;
    state_t                     w_next;
    logic [C_OPB_AWIDTH-1:0]    w_offset;
    logic [L_IW-1:0]            w_idx;
    logic                       w_hit;
    logic                       w_dec;
    logic                       w_ack;
    logic                       w_ctrl_wr;
    logic                       w_sw_cap;
    logic                       w_sw_clr;
    logic                       w_cap_evt;
    logic [C_OPB_DWIDTH-1:0]    w_rd_val;
    logic [C_OPB_DWIDTH-1:0]    r_rdata;
    logic                       r_rnw;
    logic                       r_sw_cap;
    logic [15:0]                r_cap_cnt;
    logic [C_USER_DWIDTH-1:0]   w_data [C_NUM_REGS];
    logic [C_USER_DWIDTH-1:0]   w_word [C_NUM_REGS];
    logic                       w_unused;

    assign w_offset  = OPB_ABus - L_BASE;
    assign w_idx     = w_offset[C_OPB_AWIDTH-1:2];
    assign w_hit     = OPB_select && (OPB_ABus >= L_BASE) && (OPB_ABus <= L_HIGH);
    assign w_dec     = (r_state == S_IDLE) && w_hit;
    assign w_ack     = (r_state == S_ACK);
    // Control bits live in the least significant byte, gated by its byte enable.
    assign w_ctrl_wr = !OPB_RNW && (w_idx == L_CTRL) && OPB_BE[0];
    assign w_sw_cap  = w_ctrl_wr && OPB_DBus[0];
    assign w_sw_clr  = w_ctrl_wr && OPB_DBus[1];
    assign w_cap_evt = user_capture_in || (w_ack && r_sw_cap);
    assign w_unused  = ^{OPB_seqAddr, OPB_DBus[C_OPB_DWIDTH-1:2],
                         OPB_BE[C_OPB_DWIDTH/8-1:1], w_offset[1:0]};

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_next = S_ACK;
            S_ACK:   w_next = S_HOLD;
            S_HOLD:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (w_idx == L_IW'(i)) w_rd_val[C_USER_DWIDTH-1:0] = w_word[i];
        end
        if (w_idx == L_CTRL) w_rd_val = {{(C_OPB_DWIDTH-16){1'b0}}, r_cap_cnt};
    end

    always_ff @(posedge OPB_Clk) begin
        if (!OPB_Rst) begin
            r_rdata   <= '0;
            r_rnw     <= 1'b0;
            r_sw_cap  <= 1'b0;
            r_cap_cnt <= '0;
        end else begin
            if (w_dec) begin
                r_rdata  <= w_rd_val;
                r_rnw    <= OPB_RNW;
                r_sw_cap <= w_sw_cap;
            end
            if (w_cap_evt) r_cap_cnt <= r_cap_cnt + 16'd1;
        end
    end

    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
        assign w_data[gi] = user_data_in[gi*C_USER_DWIDTH +: C_USER_DWIDTH];
        if (C_SNAP_MASK[gi]) begin : g_snap
            logic [C_USER_DWIDTH-1:0] r_snap;
            always_ff @(posedge OPB_Clk) begin
                if (!OPB_Rst)       r_snap <= '0;
                else if (w_cap_evt) r_snap <= w_data[gi];
            end
            assign w_word[gi] = r_snap;
        end else if (C_STICKY_MASK[gi]) begin : g_sticky
            logic [C_USER_DWIDTH-1:0] r_acc;
            logic                     r_clr;
            // Clearing reloads with the current data so bits arriving in the ack cycle survive.
            always_ff @(posedge OPB_Clk) begin
                if (!OPB_Rst) begin
                    r_acc <= '0;
                    r_clr <= 1'b0;
                end else begin
                    if (w_dec) r_clr <= (OPB_RNW && (w_idx == L_IW'(gi))) || w_sw_clr;
                    if (w_ack && r_clr) r_acc <= w_data[gi];
                    else                r_acc <= r_acc | w_data[gi];
                end
            end
            assign w_word[gi] = r_acc | w_data[gi];
        end else begin : g_live
            assign w_word[gi] = w_data[gi];
        end
    end

    assign Sl_xferAck = w_ack;
    assign Sl_DBus    = (w_ack && r_rnw) ? r_rdata : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Randomised bench for opb_register_bank_simulink2ppc: word0 snapshot, word1 sticky, words 2-3 live, 16-bit words.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE = 32'h01002300;
    localparam logic [31:0] CTRL = 32'h01002310;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] abus, dbus_w, sl_dbus;
    logic [3:0]  be;
    logic        rnw, sel, seqaddr, ack, err, retry, tout, ucap;
    logic [63:0] udata;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_cnt = 0;
    logic [15:0] m_snap = '0;
    logic [15:0] m_acc = '0;

    // Results of the last transaction
    logic [31:0] x_rdat;
    int          x_lat;
    bit          x_acked;
    bit          x_bad;

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc #(
        .C_NUM_REGS(4), .C_USER_DWIDTH(16),
        .C_SNAP_MASK(16'h0001), .C_STICKY_MASK(16'h0002)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst_n), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_w), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seqaddr),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err), .Sl_retry(retry),
        .Sl_toutSup(tout), .user_data_in(udata), .user_capture_in(ucap)
    );

    function automatic logic [31:0] waddr(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    // One master transaction; optional hook drives user data/capture during the ack cycle.
    task automatic opb_xfer(input logic [31:0] addr, input logic is_rd, input logic [31:0] wdat,
                            input logic [3:0] ben, input bit hk_en, input logic [63:0] hk_data,
                            input logic hk_cap);
        logic [63:0] saved;
        x_acked = 0; x_bad = 0; x_lat = 0; x_rdat = '0;
        abus = addr; rnw = is_rd; dbus_w = wdat; be = ben; sel = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ack) begin
                x_acked = 1; x_lat = n; x_rdat = sl_dbus;
                break;
            end
            if (sl_dbus !== 32'h0) x_bad = 1;
        end
        saved = udata;
        if (x_acked && hk_en) begin udata = hk_data; ucap = hk_cap; end
        @(posedge clk); #1;
        sel = 1'b0; rnw = 1'b0; dbus_w = '0; be = '0;
        if (x_acked && hk_en) begin udata = saved; ucap = 1'b0; end
        @(negedge clk);
        if (ack || sl_dbus !== 32'h0) x_bad = 1;
        @(posedge clk); #1;
    endtask

    task automatic opb_read(input logic [31:0] addr);
        opb_xfer(addr, 1'b1, 32'h0, 4'hF, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic opb_write(input logic [31:0] addr, input logic [31:0] wdat, input logic [3:0] ben);
        opb_xfer(addr, 1'b0, wdat, ben, 1'b0, 64'h0, 1'b0);
    endtask

    task automatic pulse_capture(input int n);
        ucap = 1'b1;
        repeat (n) @(posedge clk);
        #1 ucap = 1'b0;
        m_cnt = (m_cnt + n) % 65536;
        m_snap = udata[15:0];
    endtask

    task automatic pulse_sticky(input logic [15:0] p);
        udata[31:16] = p;
        @(posedge clk); #1;
        udata[31:16] = '0;
        m_acc = m_acc | p;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel = 1'b1; abus = CTRL; rnw = 1'b1; ucap = 1'b1;
        be = 4'hF; dbus_w = '0; udata = '0; seqaddr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({ack, err, retry, tout, sl_dbus} !== 36'h0) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d: ack=%b err=%b retry=%b tout=%b dbus=%h, required all 0",
                         c, ack, err, retry, tout, sl_dbus);
            end
        end
        @(posedge clk); #1;
        sel = 1'b0; ucap = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        opb_read(CTRL);
        checks++;
        if (!x_acked || x_rdat !== 32'h0) begin
            failures++;
            $display("FAIL reset_ctrl_read: acked=%0d data=%h, required ack and 00000000", x_acked, x_rdat);
        end
    endtask

    task automatic test_live;
        logic [15:0] v;
        int          idx;
        for (int k = 0; k < 6; k++) begin
            v = (k == 0) ? 16'hBEEF : 16'($urandom);
            idx = (k == 0) ? 2 : int'($urandom_range(2, 3));
            udata[idx*16 +: 16] = v;
            udata[(5-idx)*16 +: 16] = 16'($urandom);
            opb_read(waddr(idx));
            checks++;
            if (!x_acked || x_rdat !== {16'h0, v}) begin
                failures++;
                $display("FAIL live_read word%0d: acked=%0d data=%h, required %h", idx, x_acked, x_rdat, {16'h0, v});
            end
            checks++;
            if (x_lat !== 2) begin
                failures++;
                $display("FAIL live_latency: %0d cycles, required 2", x_lat);
            end
            checks++;
            if (x_bad) begin
                failures++;
                $display("FAIL live_bus_idle: ack or nonzero Sl_DBus outside the single ack cycle");
            end
        end
    endtask

    task automatic test_snapshot;
        logic [15:0] v;
        udata[15:0] = 16'h1234;
        pulse_capture(1);
        udata[15:0] = 16'h5678;
        opb_read(waddr(0));
        checks++;
        if (x_rdat !== {16'h0, m_snap}) begin
            failures++;
            $display("FAIL snap_hold: data=%h, required %h", x_rdat, {16'h0, m_snap});
        end
        opb_read(CTRL);
        checks++;
        if (x_rdat !== 32'h1) begin
            failures++;
            $display("FAIL snap_count_one: data=%h, required 00000001", x_rdat);
        end
        opb_write(waddr(0), $urandom, 4'hF);
        opb_read(waddr(0));
        checks++;
        if (x_rdat !== {16'h0, m_snap}) begin
            failures++;
            $display("FAIL snap_write_ignored: data=%h, required %h", x_rdat, {16'h0, m_snap});
        end
        // Hardware strobe and software capture in the same cycle are a single event.
        opb_xfer(CTRL, 1'b0, 32'h1, 4'hF, 1'b1, udata, 1'b1);
        m_cnt = m_cnt + 1;
        m_snap = udata[15:0];
        opb_read(CTRL);
        checks++;
        if (x_rdat !== 32'(m_cnt)) begin
            failures++;
            $display("FAIL snap_combined_count: data=%h, required %h", x_rdat, 32'(m_cnt));
        end
        for (int k = 0; k < 4; k++) begin
            v = 16'($urandom);
            udata[15:0] = v;
            if ($urandom_range(0, 1) == 1) begin
                pulse_capture(1);
            end else begin
                opb_write(CTRL, 32'h1, 4'hF);
                m_cnt = m_cnt + 1;
                m_snap = v;
            end
            udata[15:0] = ~v;
            opb_read(waddr(0));
            checks++;
            if (x_rdat !== {16'h0, m_snap}) begin
                failures++;
                $display("FAIL snap_random %0d: data=%h, required %h", k, x_rdat, {16'h0, m_snap});
            end
            opb_read(CTRL);
            checks++;
            if (x_rdat !== 32'(m_cnt)) begin
                failures++;
                $display("FAIL snap_count %0d: data=%h, required %h", k, x_rdat, 32'(m_cnt));
            end
        end
    endtask

    task automatic test_sticky;
        logic [15:0] q;
        logic [63:0] hk;
        pulse_sticky(16'h0001);
        pulse_sticky(16'h0010);
        opb_read(waddr(1));
        checks++;
        if (x_rdat !== 32'h11) begin
            failures++;
            $display("FAIL sticky_accumulate: data=%h, required 00000011", x_rdat);
        end
        m_acc = '0;
        hk = udata; hk[31:16] = 16'h0040;
        opb_xfer(waddr(1), 1'b1, 32'h0, 4'hF, 1'b1, hk, 1'b0);
        checks++;
        if (x_rdat !== 32'h0) begin
            failures++;
            $display("FAIL sticky_cleared: data=%h, required 00000000", x_rdat);
        end
        opb_read(waddr(1));
        checks++;
        if (x_rdat !== 32'h40) begin
            failures++;
            $display("FAIL sticky_ack_cycle_bit: data=%h, required 00000040", x_rdat);
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) pulse_sticky(16'($urandom) & 16'($urandom));
            opb_read(waddr(1));
            checks++;
            if (x_rdat !== {16'h0, m_acc}) begin
                failures++;
                $display("FAIL sticky_random %0d: data=%h, required %h", k, x_rdat, {16'h0, m_acc});
            end
            m_acc = '0;
        end
        pulse_sticky(16'($urandom) | 16'h8000);
        q = 16'($urandom);
        hk = udata; hk[31:16] = q;
        opb_xfer(CTRL, 1'b0, 32'h2, 4'hF, 1'b1, hk, 1'b0);
        m_acc = q;
        opb_read(waddr(1));
        checks++;
        if (x_rdat !== {16'h0, m_acc}) begin
            failures++;
            $display("FAIL sticky_clear_all: data=%h, required %h", x_rdat, {16'h0, m_acc});
        end
        m_acc = '0;
    endtask

    task automatic test_decode;
        logic [31:0] a;
        int          idx;
        for (int k = 0; k < 3; k++) begin
            idx = (k == 0) ? 60 : int'($urandom_range(5, 63));
            opb_read(waddr(idx));
            checks++;
            if (!x_acked || x_rdat !== 32'h0) begin
                failures++;
                $display("FAIL unused_index %0d: acked=%0d data=%h, required ack and 0", idx, x_acked, x_rdat);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 0)                          a = 32'h01002400;
            else if ($urandom_range(0, 1) == 1)  a = 32'h01002400 + 32'($urandom_range(0, 255) * 4);
            else                                 a = BASE - 32'($urandom_range(1, 255) * 4);
            opb_read(a);
            checks++;
            if (x_acked || x_bad) begin
                failures++;
                $display("FAIL out_of_window %h: acked=%0d bus_activity=%0d, required no response", a, x_acked, x_bad);
            end
        end
        pulse_sticky(16'h0A05);
        opb_write(CTRL, 32'h3, 4'b1110);
        opb_read(CTRL);
        checks++;
        if (x_rdat !== 32'(m_cnt)) begin
            failures++;
            $display("FAIL ctrl_be_gated_capture: data=%h, required %h", x_rdat, 32'(m_cnt));
        end
        opb_read(waddr(1));
        checks++;
        if (x_rdat !== {16'h0, m_acc}) begin
            failures++;
            $display("FAIL ctrl_be_gated_clear: data=%h, required %h", x_rdat, {16'h0, m_acc});
        end
        m_acc = '0;
    endtask

    task automatic test_wrap;
        pulse_capture(65536 - m_cnt);
        opb_read(CTRL);
        checks++;
        if (x_rdat !== 32'h0) begin
            failures++;
            $display("FAIL count_wrap: data=%h, required 00000000", x_rdat);
        end
        pulse_capture(1);
        opb_read(CTRL);
        checks++;
        if (x_rdat !== 32'h1) begin
            failures++;
            $display("FAIL count_after_wrap: data=%h, required 00000001", x_rdat);
        end
    endtask

    task automatic test_back_to_back;
        int last;
        int n_ack;
        int min_gap;
        last = -100; n_ack = 0; min_gap = 1000;
        abus = waddr(2); rnw = 1'b1; be = 4'hF; sel = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (ack) begin
                if (c - last < min_gap) min_gap = c - last;
                last = c;
                n_ack++;
            end
        end
        @(posedge clk); #1;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (min_gap < 3) begin
            failures++;
            $display("FAIL b2b_gap: minimum gap %0d cycles, required at least 3", min_gap);
        end
        checks++;
        if (n_ack != 5) begin
            failures++;
            $display("FAIL b2b_count: %0d acks in 16 cycles, required 5", n_ack);
        end
    endtask

    initial begin
        test_reset;
        test_live;
        test_snapshot;
        test_sticky;
        test_decode;
        test_wrap;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
